// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution sequencer.
package conv_pkg;

  localparam int TAPS     = 9;
  localparam int PIX_W    = 8;
  localparam int COL_BITS = 3 * PIX_W;
  localparam int VEC_W    = TAPS * PIX_W;

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  typedef logic signed [PIX_W-1:0] pix_t;

  // Pack three columns (c0 = oldest) into tap order k = row*3 + col.
  function automatic logic [VEC_W-1:0] pack_window(input logic [COL_BITS-1:0] c0,
                                                   input logic [COL_BITS-1:0] c1,
                                                   input logic [COL_BITS-1:0] c2);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int r = 0; r < 3; r++) begin
      v[(r*3+0)*PIX_W +: PIX_W] = c0[r*PIX_W +: PIX_W];
      v[(r*3+1)*PIX_W +: PIX_W] = c1[r*PIX_W +: PIX_W];
      v[(r*3+2)*PIX_W +: PIX_W] = c2[r*PIX_W +: PIX_W];
    end
    return v;
  endfunction

  // Extract signed tap k from a packed tap vector.
  function automatic pix_t unpack_tap(input logic [VEC_W-1:0] v, input int k);
    return pix_t'(v[k*PIX_W +: PIX_W]);
  endfunction

endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous first-word-fall-through result FIFO. rdata shows the head
// entry whenever the FIFO is non-empty and reads as zero when empty.
module conv_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_pop = pop && !empty;
  assign rdata  = empty ? '0 : mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; empty gates rdata, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue credit guarantees the FIFO is never written while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/conv3x3_sched.sv
// Sequencer for a 9-tap signed 8x8 MAC array (3x3 convolution).
// Builds the sliding window from 3-pixel column beats, issues one window per
// accepted RUN beat, tracks the array latency and buffers sums in a FWFT FIFO.
// RES_DEPTH must be >= MUL_LAT+1.
// Optional feature macro: CONV_RELU_EN (clamp negative sums to 0 at capture).
module conv3x3_sched
  import conv_pkg::*;
#(
  parameter int COL_W     = 8,
  parameter int MUL_LAT   = 1,
  parameter int SUM_W     = 17,
  parameter int RES_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] img_w,
  input  logic [COL_W-1:0] img_h,
  input  logic             wt_we,
  input  logic [3:0]       wt_addr,
  input  logic [7:0]       wt_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [23:0]      pix_col,
  output logic [71:0]      mac_a,
  output logic [71:0]      mac_b,
  input  logic [SUM_W-1:0] mac_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_data,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(RES_DEPTH+1);
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(RES_DEPTH);

  state_t               state;
  logic [COL_W-1:0]     w_q, h_q, col_cnt, pass_cnt;
  logic [COL_BITS-1:0]  col1_q, col2_q;
  logic [VEC_W-1:0]     kernel;
  logic                 iss_v, iss_last;
  logic [MUL_LAT-1:0]   lat_v, lat_last;
  logic [CW-1:0]        inflight, fifo_count;
  logic                 fifo_empty, fifo_full;
  logic [SUM_W:0]       fifo_rdata;
  logic [SUM_W-1:0]     cap_sum;
  logic                 accept, run_accept, last_col, last_pass, credit_ok, push;

  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_MAX;
  assign pix_ready  = (state == PRIME) || ((state == RUN) && credit_ok);
  assign accept     = pix_valid && pix_ready;
  assign run_accept = accept && (state == RUN);
  assign last_col   = (col_cnt == w_q - COL_W'(1));
  assign last_pass  = (pass_cnt == h_q - COL_W'(3));
  assign push       = lat_v[MUL_LAT-1];

  // Frame control FSM with registered busy/done.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      col_cnt  <= '0;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          w_q      <= img_w;
          h_q      <= img_h;
          col_cnt  <= '0;
          pass_cnt <= '0;
          busy     <= 1'b1;
          if (img_w >= COL_W'(3) && img_h >= COL_W'(3)) begin
            state <= PRIME;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        PRIME: if (accept) begin
          col_cnt <= col_cnt + COL_W'(1);
          if (col_cnt == COL_W'(1)) state <= RUN;
        end
        RUN: if (accept) begin
          if (last_col) begin
            col_cnt <= '0;
            if (last_pass) begin
              state <= DRAIN;
            end else begin
              pass_cnt <= pass_cnt + COL_W'(1);
              state    <= PRIME;
            end
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end
        DRAIN: if (inflight == '0 && fifo_empty) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Kernel register file, writable only while idle; taps 9..15 ignored.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      kernel <= '0;
    end else if (state == IDLE && wt_we && wt_addr < 4'd9) begin
      kernel[int'(wt_addr)*PIX_W +: PIX_W] <= wt_data;
    end
  end

  // Sliding window and issue register: mac_a/mac_b hold the last issued op.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      col1_q   <= '0;
      col2_q   <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      iss_v    <= 1'b0;
      iss_last <= 1'b0;
    end else begin
      iss_v    <= 1'b0;
      iss_last <= 1'b0;
      if (accept) begin
        col1_q <= col2_q;
        col2_q <= pix_col;
      end
      if (run_accept) begin
        mac_a    <= pack_window(col1_q, col2_q, pix_col);
        mac_b    <= kernel;
        iss_v    <= 1'b1;
        iss_last <= last_col && last_pass;
      end
    end
  end

  // Array latency tracking and outstanding-op counter for issue credit.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      lat_v    <= '0;
      lat_last <= '0;
      inflight <= '0;
    end else begin
      lat_v[0]    <= iss_v;
      lat_last[0] <= iss_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        lat_v[i]    <= lat_v[i-1];
        lat_last[i] <= lat_last[i-1];
      end
      case ({run_accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Capture value: optional ReLU, otherwise the array sum as-is.
  // NOTE: cap_sum gets a default before any conditional override, so no latch is inferred.
  always_comb begin
    cap_sum = mac_sum;
`ifdef CONV_RELU_EN
    if (mac_sum[SUM_W-1]) cap_sum = '0;
`else
    cap_sum = mac_sum;
`endif
  end

  conv_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (SUM_W + 1)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (push),
    .wdata ({lat_last[MUL_LAT-1], cap_sum}),
    .pop   (res_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_rdata[SUM_W-1:0];
  assign res_last  = fifo_rdata[SUM_W];

endmodule

// File: tb/tb_conv3x3_sched.sv
// Testbench for conv3x3_sched: MAC array model, directed frames, scoreboard.
module tb_conv3x3_sched;
  import conv_pkg::*;

  localparam int COL_W     = 8;
  localparam int MUL_LAT   = 1;
  localparam int SUM_W     = 17;
  localparam int RES_DEPTH = 4;

  logic             sys_clk = 1'b0;
  logic             rst, start, wt_we, pix_valid, pix_ready;
  logic [COL_W-1:0] img_w, img_h;
  logic [3:0]       wt_addr;
  logic [7:0]       wt_data;
  logic [23:0]      pix_col;
  logic [71:0]      mac_a, mac_b;
  logic [SUM_W-1:0] mac_sum;
  logic             res_valid, res_ready, res_last, busy, done;
  logic [SUM_W-1:0] res_data;

  typedef struct {int data; bit last;} exp_t;
  exp_t exp_q[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  int  done_cnt = 0;
  int  n_pop    = 0;
  int  beats_acc = 0;
  bit  drv_stop = 0;
  bit  drv_busy = 0;

  conv3x3_sched #(
    .COL_W(COL_W), .MUL_LAT(MUL_LAT), .SUM_W(SUM_W), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_col(pix_col),
    .mac_a(mac_a), .mac_b(mac_b), .mac_sum(mac_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  // MAC array model: one register stage, sum truncated to SUM_W.
  always @(posedge sys_clk) begin : mac_model
    int acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      acc += int'(unpack_tap(mac_a, k)) * int'(unpack_tap(mac_b, k));
    mac_sum <= acc[SUM_W-1:0];
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Monitor: compares every popped result against the scoreboard head.
  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (done) done_cnt++;
    if (!rst && res_valid && res_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", $signed(res_data), 0);
      end else begin
        e = exp_q.pop_front();
        check("res_data", $signed(res_data), e.data);
        check("res_last", int'(res_last), int'(e.last));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic push_exp(input int d, input bit l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic write_wt(input int addr, input int val);
    wt_we = 1'b1; wt_addr = addr[3:0]; wt_data = val[7:0];
    tick();
    wt_we = 1'b0;
  endtask

  task automatic load_kernel(input int centre_only, input int val);
    for (int k = 0; k < TAPS; k++)
      write_wt(k, (centre_only == 0 || k == 4) ? val : 0);
  endtask

  function automatic logic [7:0] pix_val(input int pat, input int cval, input int r, input int c);
    int v;
    case (pat)
      1:       v = c;
      2:       v = r * 16 + c;
      default: v = cval;
    endcase
    return v[7:0];
  endfunction

  task automatic send_beat(input logic [23:0] col, output int waits);
    int budget;
    budget = 300;
    waits = 0;
    pix_valid = 1'b1;
    pix_col = col;
    while (!pix_ready && !drv_stop && budget > 0) begin
      tick(); waits++; budget--;
    end
    if (!drv_stop) begin
      if (!pix_ready) begin
        check("beat_accept", int'(pix_ready), 1);
        drv_stop = 1'b1;
      end else begin
        tick();
        beats_acc++;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic drive_frame(input int w, input int h, input int pat, input int cval);
    int waits;
    for (int p = 0; p <= h - 3 && !drv_stop; p++)
      for (int c = 0; c < w && !drv_stop; c++) begin
        send_beat({pix_val(pat, cval, p+2, c), pix_val(pat, cval, p+1, c),
                   pix_val(pat, cval, p, c)}, waits);
        if (c < 2 && !drv_stop) check("prime_beat_wait", waits, 0);
      end
  endtask

  task automatic start_frame(input int w, input int h);
    img_w = w[7:0]; img_h = h[7:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    check(name, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, b0, p0;
    rst = 1'b1; start = 0; wt_we = 0; wt_addr = 0; wt_data = 0;
    img_w = 0; img_h = 0; pix_valid = 0; pix_col = 0; res_ready = 0;
    tick(3);

    // Reset state
    check("rst_pix_ready", int'(pix_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mac_a_zero", int'(mac_a == '0), 1);
    rst = 1'b0;
    tick(2);

    // 1: all-ones kernel, 4x4 of 2 -> four results of 18
    load_kernel(0, 1);
    res_ready = 1'b1;
    push_exp(18, 0); push_exp(18, 0); push_exp(18, 0); push_exp(18, 1);
    d0 = done_cnt;
    start_frame(4, 4);
    check("t1_busy", int'(busy), 1);
    drv_stop = 0;
    drive_frame(4, 4, 0, 2);
    wait_done(d0, 100, "t1_done");
    check("t1_queue_empty", exp_q.size(), 0);
    tick();
    check("t1_busy_low", int'(busy), 0);

    // 2: centre tap only, 5x3 ramp (pixel = column) -> 1,2,3
    load_kernel(1, 1);
    push_exp(1, 0); push_exp(2, 0); push_exp(3, 1);
    d0 = done_cnt;
    start_frame(5, 3);
    drive_frame(5, 3, 2 - 1, 0);
    wait_done(d0, 100, "t2_done");
    check("t2_queue_empty", exp_q.size(), 0);
    tick();

    // 3: consumer stalled on 8x5 frame; FIFO fills, issue stops, then drains
    res_ready = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 6; c++)
        push_exp((p + 1) * 16 + c + 1, (p == 2 && c == 5));
    d0 = done_cnt; b0 = beats_acc; p0 = n_pop;
    start_frame(8, 5);
    drv_busy = 1'b1;
    fork
      begin drive_frame(8, 5, 2, 0); drv_busy = 1'b0; end
    join_none
    tick(40);
    check("t3_beats_before_stall", beats_acc - b0, 2 + RES_DEPTH);
    check("t3_pix_ready_low", int'(pix_ready), 0);
    check("t3_res_valid", int'(res_valid), 1);
    check("t3_no_pops", n_pop - p0, 0);
    res_ready = 1'b1;
    wait_done(d0, 600, "t3_done");
    check("t3_pop_count", n_pop - p0, 18);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_driver_idle", int'(drv_busy), 0);
    tick();

    // 5: weights -128, pixels 127 -> wrapped sum, or 0 with ReLU
    load_kernel(0, -128);
`ifdef CONV_RELU_EN
    push_exp(0, 1);
`else
    push_exp(-15232, 1);
`endif
    d0 = done_cnt;
    start_frame(3, 3);
    drive_frame(3, 3, 0, 127);
    wait_done(d0, 100, "t5_done");
    check("t5_queue_empty", exp_q.size(), 0);
    tick();

    // 4: degenerate width -> straight to DONE
    d0 = done_cnt; p0 = n_pop;
    start_frame(2, 5);
    check("t4_pix_ready", int'(pix_ready), 0);
    check("t4_res_valid", int'(res_valid), 0);
    tick(2);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_busy_low", int'(busy), 0);
    check("t4_no_results", n_pop - p0, 0);

    // 6: reset mid-RUN with results buffered
    res_ready = 1'b0;
    start_frame(8, 5);
    drv_busy = 1'b1;
    fork
      begin drive_frame(8, 5, 0, 1); drv_busy = 1'b0; end
    join_none
    tick(30);
    check("t6_fifo_nonempty", int'(res_valid), 1);
    d0 = done_cnt;
    drv_stop = 1'b1;
    rst = 1'b1;
    #1;
    check("t6_res_valid", int'(res_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_mac_b_zero", int'(mac_b == '0), 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10 && drv_busy; i++) tick();
    check("t6_driver_stopped", int'(drv_busy), 0);
    tick(5);
    check("t6_no_done", done_cnt - d0, 0);
    exp_q.delete();
    drv_stop = 1'b0;

    // After reset the kernel is cleared: a 3x3 frame of 5s yields 0
    res_ready = 1'b1;
    push_exp(0, 1);
    d0 = done_cnt;
    start_frame(3, 3);
    drive_frame(3, 3, 0, 5);
    wait_done(d0, 100, "t6_post_done");
    check("t6_post_queue_empty", exp_q.size(), 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
